// File: rtl/led_pkg.sv
// Shared types and helpers for the multi-channel LED blink controller.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_BLINK   = 2'd2,
    LED_ONESHOT = 2'd3
  } led_mode_t;

  function automatic logic lit_on_load(input led_mode_t m);
    return (m == LED_ON) || (m == LED_ONESHOT);
  endfunction

endpackage

// File: rtl/led_chan.sv
// One LED channel: config registers, phase counter, led and done flops.
module led_chan
  import led_pkg::*;
#(
  parameter int CNT_WIDTH = 6,
  parameter int SRC_W     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 tick_i,
  input  logic                 wr_en_i,
  input  led_mode_t            cfg_mode_i,
  input  logic [SRC_W-1:0]     cfg_src_i,
  input  logic [CNT_WIDTH-1:0] cfg_div_i,
  output logic [SRC_W-1:0]     src_o,
  output logic                 led_o,
  output logic                 done_o
);

  led_mode_t            mode_q, mode_d;
  logic [SRC_W-1:0]     src_q, src_d;
  logic [CNT_WIDTH-1:0] div_q, div_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 led_q, led_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] div_eff;
  logic                 last;

  assign div_eff = (div_q == '0) ? CNT_WIDTH'(1) : div_q;
  assign last    = (cnt_q == div_eff - CNT_WIDTH'(1));

  always_comb begin
    mode_d = mode_q;
    src_d  = src_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    led_d  = led_q;
    done_d = 1'b0;
    // A write on the same cycle as a tick wins; the tick is dropped.
    if (wr_en_i) begin
      mode_d = cfg_mode_i;
      src_d  = cfg_src_i;
      div_d  = cfg_div_i;
      cnt_d  = '0;
      led_d  = lit_on_load(cfg_mode_i);
    end else if (tick_i) begin
      unique case (mode_q)
        LED_BLINK: begin
          if (last) begin
            led_d = ~led_q;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        LED_ONESHOT: begin
          if (last) begin
            led_d  = 1'b0;
            mode_d = LED_OFF;
            cnt_d  = '0;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mode_q <= LED_OFF;
      src_q  <= '0;
      div_q  <= CNT_WIDTH'(1);
      cnt_q  <= '0;
      led_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      src_q  <= src_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      done_q <= done_d;
    end
  end

  assign src_o  = src_q;
  assign led_o  = led_q;
  assign done_o = done_q;

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED driver: config decode, per-channel tick mux, channel array.
module led_blink_ctrl
  import led_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int NUM_TICKS = 3,
  parameter int CNT_WIDTH = 6,
  localparam int SRC_W = (NUM_TICKS > 1) ? $clog2(NUM_TICKS) : 1,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_50m,
  input  logic                 reset_n,
  input  logic [NUM_TICKS-1:0] tick_in,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [1:0]           cfg_mode,
  input  logic [SRC_W-1:0]     cfg_src,
  input  logic [CNT_WIDTH-1:0] cfg_div,
  output logic [NUM_CH-1:0]    led_out,
  output logic [NUM_CH-1:0]    oneshot_done
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SRC_W-1:0] src;
    logic             wr_en;
    logic             tick;

    assign wr_en = cfg_we && (int'(cfg_ch) == i);
    // Out-of-range source indices never tick.
    assign tick  = (int'(src) < NUM_TICKS) ? tick_in[src] : 1'b0;

    led_chan #(
      .CNT_WIDTH (CNT_WIDTH),
      .SRC_W     (SRC_W)
    ) u_chan (
      .clk_i      (clk_50m),
      .rst_n_i    (reset_n),
      .tick_i     (tick),
      .wr_en_i    (wr_en),
      .cfg_mode_i (led_mode_t'(cfg_mode)),
      .cfg_src_i  (cfg_src),
      .cfg_div_i  (cfg_div),
      .src_o      (src),
      .led_o      (led_out[i]),
      .done_o     (oneshot_done[i])
    );
  end

endmodule
